// File: rtl/mcp_adder_host_driver.sv
// Host-side initiator for the serial-load / indexed-readback adder test port.
// Define MCP_DRV_CHECK_EN to add the registered reference adder that drives error.
module mcp_adder_host_driver #(
    parameter int BITS       = 64,
    parameter int SETTLE     = 2,
    parameter int SAMPLE_DLY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BITS-1:0]         x_in,
    input  logic [BITS-1:0]         y_in,
    output logic                    ser_x,
    output logic                    ser_y,
    output logic                    shift_en,
    output logic [$clog2(BITS)-1:0] bit_sel,
    input  logic                    sum_bit,
    output logic                    busy,
    output logic                    done,
    output logic [BITS-1:0]         result,
    output logic                    error
);

    // state    | meaning
    // S_IDLE   | waiting for start
    // S_SHIFT  | operands streamed out MSB first with shift_en high
    // S_SETTLE | DUT sum register settling, shift_en low
    // S_SELECT | bit_sel held; sum_bit captured on last edge of window
    // S_DONE   | one-cycle done pulse

    localparam int IDX_W   = $clog2(BITS);
    localparam int CNT_A   = (BITS > SETTLE) ? BITS : SETTLE;
    localparam int CNT_MAX = (CNT_A > SAMPLE_DLY + 1) ? CNT_A : SAMPLE_DLY + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_SETTLE,
        S_SELECT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BITS-1:0]   sx_q, sx_d;
    logic [BITS-1:0]   sy_q, sy_d;
    logic              ser_x_q, ser_x_d;
    logic              ser_y_q, ser_y_d;
    logic              shift_en_q, shift_en_d;
    logic [IDX_W-1:0]  bit_sel_q, bit_sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BITS-1:0]   result_q, result_d;
    logic              error_q, error_d;
`ifdef MCP_DRV_CHECK_EN
    logic [BITS-1:0]   ref_q, ref_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        ser_x_d    = ser_x_q;
        ser_y_d    = ser_y_q;
        shift_en_d = shift_en_q;
        bit_sel_d  = bit_sel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
`ifdef MCP_DRV_CHECK_EN
        error_d    = error_q;
        ref_d      = ref_q;
`else
        error_d    = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SHIFT;
                    // MSB goes out right away; the shift regs keep the remaining bits
                    ser_x_d    = x_in[BITS-1];
                    ser_y_d    = y_in[BITS-1];
                    sx_d       = {x_in[BITS-2:0], 1'b0};
                    sy_d       = {y_in[BITS-2:0], 1'b0};
                    shift_en_d = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = CNT_W'(BITS - 1);
                    bit_sel_d  = '0;
                    result_d   = '0;
                    error_d    = 1'b0;
`ifdef MCP_DRV_CHECK_EN
                    ref_d      = x_in + y_in;
`endif
                end
            end

            S_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d    = S_SETTLE;
                    shift_en_d = 1'b0;
                    ser_x_d    = 1'b0;
                    ser_y_d    = 1'b0;
                    cnt_d      = CNT_W'(SETTLE - 1);
                end else begin
                    ser_x_d = sx_q[BITS-1];
                    ser_y_d = sy_q[BITS-1];
                    sx_d    = {sx_q[BITS-2:0], 1'b0};
                    sy_d    = {sy_q[BITS-2:0], 1'b0};
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end

            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d   = S_SELECT;
                    bit_sel_d = '0;
                    cnt_d     = CNT_W'(SAMPLE_DLY);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_SELECT: begin
                if (cnt_q == '0) begin
                    result_d[bit_sel_q] = sum_bit;
                    if (bit_sel_q == IDX_W'(BITS - 1)) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        bit_sel_d = '0;
`ifdef MCP_DRV_CHECK_EN
                        error_d   = (result_d != ref_q);
`endif
                    end else begin
                        bit_sel_d = bit_sel_q + IDX_W'(1);
                        cnt_d     = CNT_W'(SAMPLE_DLY);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            ser_x_q    <= 1'b0;
            ser_y_q    <= 1'b0;
            shift_en_q <= 1'b0;
            bit_sel_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            ser_x_q    <= ser_x_d;
            ser_y_q    <= ser_y_d;
            shift_en_q <= shift_en_d;
            bit_sel_q  <= bit_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            error_q    <= error_d;
        end
    end

`ifdef MCP_DRV_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
        end else begin
            ref_q <= ref_d;
        end
    end
`endif

    assign ser_x    = ser_x_q;
    assign ser_y    = ser_y_q;
    assign shift_en = shift_en_q;
    assign bit_sel  = bit_sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign error    = error_q;

endmodule

// File: tb/tb_mcp_adder_host_driver.sv
// Bench for mcp_adder_host_driver: models the serial-load adder (shift regs, registered sum,
// indexed readback with optional stuck-at-0 bits) and checks streams, timing and results.
module tb_mcp_adder_host_driver;

    localparam int BITS       = 8;
    localparam int SETTLE     = 2;
    localparam int SAMPLE_DLY = 1;
    localparam int LAT        = BITS + SETTLE + BITS * (SAMPLE_DLY + 1);
`ifdef MCP_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BITS-1:0]  x_in = '0;
    logic [BITS-1:0]  y_in = '0;
    logic             ser_x, ser_y, shift_en, sum_bit, busy, done, error;
    logic [2:0]       bit_sel;
    logic [BITS-1:0]  result;

    logic [BITS-1:0]  mx = '0;
    logic [BITS-1:0]  my = '0;
    logic [BITS-1:0]  msum = '0;
    logic [BITS-1:0]  stuck = '0;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mcp_adder_host_driver #(
        .BITS(BITS), .SETTLE(SETTLE), .SAMPLE_DLY(SAMPLE_DLY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
        .ser_x(ser_x), .ser_y(ser_y), .shift_en(shift_en), .bit_sel(bit_sel),
        .sum_bit(sum_bit), .busy(busy), .done(done), .result(result), .error(error)
    );

    // Adder under test: serial load, registered sum, indexed readback
    always @(posedge clk) begin
        if (shift_en) begin
            mx <= {mx[BITS-2:0], ser_x};
            my <= {my[BITS-2:0], ser_y};
        end
        msum <= mx + my;
    end
    assign sum_bit = msum[bit_sel] & ~stuck[bit_sel];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction. pa/pb: cycles in which a stray start is pulsed; rst_at: cycle of reset abort.
    task automatic run(input logic [BITS-1:0] x, input logic [BITS-1:0] y,
                       input logic [BITS-1:0] stk, input int pa, input int pb, input int rst_at);
        logic [BITS-1:0] exp_res;
        logic            exp_err;
        bit              seen_done;
        exp_res   = BITS'(x + y) & ~stk;
        exp_err   = CHK && (exp_res != BITS'(x + y));
        seen_done = 1'b0;
        stuck     = stk;
        @(negedge clk);
        start = 1'b1;
        x_in  = x;
        y_in  = y;
        @(posedge clk);
        for (int c = 1; c <= LAT + 6; c++) begin
            @(negedge clk);
            start = (c == pa) || (c == pb);
            x_in  = BITS'($urandom);
            y_in  = BITS'($urandom);
            if (rst_at > 0 && c >= rst_at) begin
                if (c == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_abort_outs", {busy, done, shift_en, ser_x, ser_y, error, bit_sel, result}, '0);
                end else begin
                    if (c == rst_at + 2) rst_n = 1'b1;
                    if (done) seen_done = 1'b1;
                end
            end else begin
                if (c <= BITS) begin
                    chk("ser_x", {63'd0, ser_x}, {63'd0, x[BITS-c]});
                    chk("ser_y", {63'd0, ser_y}, {63'd0, y[BITS-c]});
                    chk("shift_en_on", {63'd0, shift_en}, 64'd1);
                end
                if (c == BITS + 1) chk("shift_en_off", {63'd0, shift_en}, 64'd0);
                if (c == 1 || c == LAT || c == LAT + 1)
                    chk("busy", {63'd0, busy}, {63'd0, c <= LAT});
                if (done) begin
                    chk("done_cycle", 64'(c), 64'(LAT + 1));
                    chk("result", {56'd0, result}, {56'd0, exp_res});
                    chk("error", {63'd0, error}, {63'd0, exp_err});
                    seen_done = 1'b1;
                end
            end
        end
        if (rst_at > 0) chk("no_done_after_abort", {63'd0, seen_done}, 64'd0);
        else            chk("done_seen", {63'd0, seen_done}, 64'd1);
        start = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_outs", {busy, done, shift_en, ser_x, ser_y, error, bit_sel, result}, '0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        run(8'h5A, 8'h33, 8'h00, 0, 0, 0);
        run(8'hFF, 8'h01, 8'h00, 0, 0, 0);
        run(8'h08, 8'h00, 8'h08, 0, 0, 0);
        run(8'h08, 8'h00, 8'h00, 0, 0, 0);
        run(8'hA5, 8'hC3, 8'h00, 0, 0, 4);
        run(8'h01, 8'h02, 8'h00, 0, 0, 0);
        run(8'h11, 8'h22, 8'h00, 5, 20, 0);
        for (int i = 0; i < 8; i++) begin
            run(BITS'($urandom), BITS'($urandom), (i % 3 == 2) ? BITS'($urandom) : '0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
